// File: rtl/ctrl_pipeline_if.sv
// Intake, memory handshake and per-stage observation bundle for ctrl_pipeline.
// Control words travel as raw 16-bit vectors here so this file has no package dependency.
interface ctrl_pipeline_if #(
    parameter int DEPTH = 5
);
    localparam int CW_W = 16;

    logic                           in_valid;
    logic                           in_ready;
    logic [3:0]                     opcode;
    logic                           imm_check;
    logic                           stall;
    logic                           flush;
    logic                           mem_resp;
    logic                           mem_read;
    logic                           mem_write;
    logic [DEPTH-1:0]               stage_valid;
    logic [DEPTH-1:0][CW_W-1:0]     stage_ctrl;
    logic                           illegal_op;
    logic [15:0]                    retire_count;

    modport slave (
        input  in_valid, opcode, imm_check, stall, flush, mem_resp,
        output in_ready, mem_read, mem_write, stage_valid, stage_ctrl,
        output illegal_op, retire_count
    );

    modport master (
        output in_valid, opcode, imm_check, stall, flush, mem_resp,
        input  in_ready, mem_read, mem_write, stage_valid, stage_ctrl,
        input  illegal_op, retire_count
    );
endinterface

// File: rtl/ctrl_pipeline.sv
// lc3b control-word pipeline: intake decode, DEPTH registered stages, memory-wait
// freeze, younger-stage flush and a wrapping retirement counter.
package lc3b_pkg;
    typedef logic [3:0] lc3b_opcode;
    typedef logic [2:0] lc3b_aluop;

    localparam lc3b_opcode op_br  = 4'b0000;
    localparam lc3b_opcode op_add = 4'b0001;
    localparam lc3b_opcode op_and = 4'b0101;
    localparam lc3b_opcode op_ldr = 4'b0110;
    localparam lc3b_opcode op_str = 4'b0111;
    localparam lc3b_opcode op_not = 4'b1001;

    localparam lc3b_aluop alu_add  = 3'd0;
    localparam lc3b_aluop alu_and  = 3'd1;
    localparam lc3b_aluop alu_not  = 3'd2;
    localparam lc3b_aluop alu_pass = 3'd3;

    typedef struct packed {
        lc3b_opcode opcode;
        lc3b_aluop  aluop;
        logic       load_regfile;
        logic       load_cc;
        logic       sr2mux_sel;
        logic       mem_read;
        logic       mem_write;
        logic       addr1mux_sel;
        logic [1:0] addr2mux_sel;
        logic       regfilemux_sel;
    } lc3b_control_word;
endpackage

module ctrl_pipeline
    import lc3b_pkg::*;
#(
    parameter int DEPTH     = 5,
    parameter int MEM_STAGE = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    ctrl_pipeline_if.slave    bus
);
    lc3b_control_word             dec;
    logic                         dec_illegal;
    lc3b_control_word [DEPTH-1:0] stg_ctrl;
    logic [DEPTH-1:0]             stg_valid;
    logic                         illegal_q;
    logic [15:0]                  retire_q;
    logic                         mem_wait;
    logic                         hold;
    logic                         ready;
    logic                         accept;

    always_comb begin
        dec         = '0;
        dec_illegal = 1'b0;
        dec.opcode  = bus.opcode;
        case (bus.opcode)
            op_add: begin
                dec.aluop        = alu_add;
                dec.load_regfile = 1'b1;
                dec.load_cc      = 1'b1;
                dec.sr2mux_sel   = bus.imm_check;
            end
            op_and: begin
                dec.aluop        = alu_and;
                dec.load_regfile = 1'b1;
                dec.load_cc      = 1'b1;
                dec.sr2mux_sel   = bus.imm_check;
            end
            op_not: begin
                dec.aluop        = alu_not;
                dec.load_regfile = 1'b1;
                dec.load_cc      = 1'b1;
            end
            op_ldr: begin
                dec.mem_read       = 1'b1;
                dec.load_regfile   = 1'b1;
                dec.load_cc        = 1'b1;
                dec.addr1mux_sel   = 1'b1;
                dec.addr2mux_sel   = 2'b01;
                dec.regfilemux_sel = 1'b1;
            end
            op_str: begin
                dec.mem_write    = 1'b1;
                dec.addr1mux_sel = 1'b1;
                dec.addr2mux_sel = 2'b01;
            end
            op_br: begin
            end
            default: begin
                // Unsupported opcodes still occupy a slot, but as an all-zero word.
                dec         = '0;
                dec_illegal = 1'b1;
            end
        endcase
    end

    assign mem_wait = stg_valid[MEM_STAGE]
                    & (stg_ctrl[MEM_STAGE].mem_read | stg_ctrl[MEM_STAGE].mem_write)
                    & ~bus.mem_resp;
    assign hold     = bus.stall | mem_wait;
    assign ready    = ~hold & ~bus.flush;
    assign accept   = bus.in_valid & ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stg_valid <= '0;
            stg_ctrl  <= '0;
            illegal_q <= 1'b0;
            retire_q  <= '0;
        end else begin
            illegal_q <= accept & dec_illegal;
            if (!hold) begin
                stg_valid <= {stg_valid[DEPTH-2:0], accept};
                stg_ctrl  <= {stg_ctrl[DEPTH-2:0], dec};
                if (stg_valid[DEPTH-1]) begin
                    retire_q <= retire_q + 16'd1;
                end
            end
            // Flush overrides the shift for younger stages and bubbles MEM_STAGE on advance.
            if (bus.flush) begin
                for (int k = 0; k < MEM_STAGE; k++) begin
                    stg_valid[k] <= 1'b0;
                end
                if (!hold) begin
                    stg_valid[MEM_STAGE] <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready     = ready;
    assign bus.stage_valid  = stg_valid;
    assign bus.stage_ctrl   = stg_ctrl;
    assign bus.illegal_op   = illegal_q;
    assign bus.retire_count = retire_q;
    assign bus.mem_read     = stg_valid[MEM_STAGE] & stg_ctrl[MEM_STAGE].mem_read;
    assign bus.mem_write    = stg_valid[MEM_STAGE] & stg_ctrl[MEM_STAGE].mem_write;
endmodule
